// File: rtl/video_timing_pkg.sv
// Shared timing constants, colour-bar table and helpers for the raster timing generator.
// The optional colour-bar test pattern is enabled with the TEST_PATTERN_EN macro.
package video_timing_pkg;

  // One complete raster description (all values in pixels or lines).
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  // CEA-861 1280x720@60 (74.25 MHz pixel clock).
  localparam timing_t TIMING_720P60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  // VESA 640x480@60 (25.175 MHz pixel clock).
  localparam timing_t TIMING_480P60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Total pixels per line or lines per frame.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// Fixed-depth shift register; every stage loads RST_VAL on a synchronous active-low reset.
module sync_delay #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  // Shift d through DEPTH registers; reset clears the whole line so nothing stale leaks out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RST_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI/HDMI output stage.
// x/y/active_req/line_start/frame_start are undelayed (for the pixel source);
// hsync/vsync/de (and tp_rgb) are delayed PIPE_DLY cycles to line up with the
// pixel source's RGB at the TMDS block. Optional macro: TEST_PATTERN_EN adds
// an 8-bar colour pattern on tp_rgb; otherwise tp_rgb is tied to zero.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active_req,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [23:0]   tp_rgb
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Decode bounds are one bit wider than the counters so a total of exactly 2^CW still fits.
  localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_START  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_START  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_pipe_dly
    $error("video_timing_gen: PIPE_DLY must be in 1..8");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic [CW:0]   h_ext;
  logic [CW:0]   v_ext;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    sync_raw;
  logic [2:0]    sync_dly;

  // Raster counters: advance one pixel per enabled cycle, wrap line then frame.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign x     = h;
  assign y     = v;
  assign h_ext = {1'b0, h};
  assign v_ext = {1'b0, v};

  // Undelayed decode; a frozen raster (en=0) reports nothing active and no sync.
  assign active_req  = en && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign line_start  = en && (h == '0);
  assign frame_start = en && (h == '0) && (v == '0);
  assign hs_raw      = en && (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_raw      = en && (v_ext >= VS_START) && (v_ext < VS_END);

  // Polarity is applied before the delay line so the registers hold output levels directly.
  assign sync_raw = {hs_raw ? HS_POL : ~HS_POL, vs_raw ? VS_POL : ~VS_POL, active_req};

  sync_delay #(
    .W       (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_dly (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .d     (sync_raw),
    .q     (sync_dly)
  );

  assign {hsync, vsync, de} = sync_dly;

`ifdef TEST_PATTERN_EN
  logic [2:0]  bar_sel;
  logic [23:0] rgb_raw;

  // Bar index = x*8/H_ACTIVE; only meaningful while active, so gate to black otherwise.
  // Because rgb_raw is zero whenever active_req is zero and both share one reset,
  // the delayed tp_rgb is zero whenever delayed de is zero.
  assign bar_sel = 3'(({3'b000, h} << 3) / (CW+3)'(H_ACTIVE));
  assign rgb_raw = active_req ? BAR_RGB[bar_sel] : 24'h0;

  sync_delay #(
    .W       (24),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (24'h0)
  ) u_tp_dly (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .d     (rgb_raw),
    .q     (tp_rgb)
  );
`else
  assign tp_rgb = 24'h0;
`endif

endmodule
